// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file dump reader.
//   REG_AW / REG_DW / REG_N : default index width, data width and register count
//   dump_state_e            : reader FSM state encoding
package regfile_dump_reader_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_N  = 32;

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_SETUP = 2'd1,
        DUMP_SEND  = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying register dump beats.
//   dump_data  : captured register value
//   dump_idx   : register index of dump_data
//   dump_valid : beat valid
//   dump_ready : consumer accepts the beat on valid && ready at the clock edge
//   dump_last  : beat carries the final register index
// master = dump reader, slave = consumer (display / UART path).
interface regfile_dump_reader_if #(
    parameter int AW = 5,
    parameter int DW = 32
) ();

    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_valid;
    logic          dump_ready;
    logic          dump_last;

    modport master (
        output dump_data,
        output dump_idx,
        output dump_valid,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_data,
        input  dump_idx,
        input  dump_valid,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Register file dump reader.
// On a start pulse, walks the RegFile debug read port (regX/Xdat) from index 0
// to NREG-1 and streams every value out as a valid/ready beat. The writeback
// port is snooped so a consumer can tell when the snapshot was overtaken by a
// write during the dump.
// Ports:
//   PCclk      : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle dump request, ignored while busy
//   regX       : registered debug read index to RegFile
//   Xdat       : debug read data from RegFile (combinational from regX)
//   snoop_we   : copy of RegWrite
//   snoop_addr : copy of regW
//   dump       : beat stream (master side)
//   busy       : dump in progress
//   done       : one-cycle pulse after the last beat is accepted
//   dirty      : snapshot inconsistent, sticky until the next accepted start
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NREG = REG_N,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                   PCclk,
    input  logic                   rst,
    input  logic                   start,
    output logic [AW-1:0]          regX,
    input  logic [DW-1:0]          Xdat,
    input  logic                   snoop_we,
    input  logic [AW-1:0]          snoop_addr,
    regfile_dump_reader_if.master  dump,
    output logic                   busy,
    output logic                   done,
    output logic                   dirty
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    dump_state_e   state_reg, state_next;
    logic [AW-1:0] regx_reg,  regx_next;
    logic [DW-1:0] data_reg,  data_next;
    logic [AW-1:0] idx_reg,   idx_next;
    logic          valid_reg, valid_next;
    logic          last_reg,  last_next;
    logic          busy_reg,  busy_next;
    logic          done_reg,  done_next;
    logic          dirty_reg, dirty_next;

    logic beat_accept;
    logic snoop_hit;

    assign beat_accept = valid_reg && dump.dump_ready;

    // A write to a register already captured, or to the one being captured
    // this very edge (RegFile updates on the same edge, so the capture sees
    // the old value), makes the snapshot stale. Register 0 is hardwired zero.
    assign snoop_hit = busy_reg && snoop_we && (snoop_addr != '0) &&
                       (snoop_addr <= regx_reg);

    // State register and datapath registers
    always_ff @(posedge PCclk) begin
        if (rst) begin
            state_reg <= DUMP_IDLE;
            regx_reg  <= '0;
            data_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dirty_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            regx_reg  <= regx_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            dirty_reg <= dirty_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DUMP_IDLE: begin
                if (start) begin
                    state_next = DUMP_SETUP;
                end
            end
            DUMP_SETUP: begin
                state_next = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (beat_accept) begin
                    state_next = last_reg ? DUMP_IDLE : DUMP_SETUP;
                end
            end
            default: begin
                state_next = DUMP_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        regx_next  = regx_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        dirty_next = dirty_reg;

        case (state_reg)
            DUMP_IDLE: begin
                if (start) begin
                    regx_next  = '0;
                    busy_next  = 1'b1;
                    dirty_next = 1'b0;
                end
            end
            DUMP_SETUP: begin
                // regX was set on the previous edge, so Xdat has had a full
                // cycle to settle before it is captured here.
                data_next  = Xdat;
                idx_next   = regx_reg;
                valid_next = 1'b1;
                last_next  = (regx_reg == LAST_IDX);
            end
            DUMP_SEND: begin
                if (beat_accept) begin
                    valid_next = 1'b0;
                    if (last_reg) begin
                        // Index stops at NREG-1; it is never advanced past it.
                        last_next = 1'b0;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        regx_next = regx_reg + 1'b1;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
                last_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase

        // busy is low in IDLE, so this never collides with the clear on start.
        if (snoop_hit) begin
            dirty_next = 1'b1;
        end
    end

    assign regX            = regx_reg;
    assign dump.dump_data  = data_reg;
    assign dump.dump_idx   = idx_reg;
    assign dump.dump_valid = valid_reg;
    assign dump.dump_last  = last_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign dirty           = dirty_reg;

endmodule
